// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALUop encodings, EX/MEM payload and
// memory-stage FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_JAL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'b10001;
  localparam logic [OP_W-1:0] OP_BLT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_LW   = 5'b10100;
  localparam logic [OP_W-1:0] OP_SW   = 5'b10101;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b01101;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b01110;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00101;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // EX/MEM latch contents; only the low address bits are kept for alignment.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
    logic [1:0]       addr_lo;
  } ex_mem_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-memory req/ack sequencer with timeout, kill tracking and load-data
// capture for the memory stage.
module mem_bus_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        start_we_i,
  input  logic [29:0] start_addr_i,
  input  logic [31:0] start_wdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_c_o,
  output logic        done_c_o,
  output logic        wb_ok_c_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic             tout_q, tout_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      tout_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      tout_q  <= tout_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    tout_d  = tout_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        // The bus cannot be aborted; a flush only suppresses writeback.
        if (flush_i) kill_d = 1'b1;
        if (mem_ack_i) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem_rdata_i;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          tout_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!stall_i) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // start_i implies a load edge, so this covers IDLE and DONE exit alike.
    if (start_i && (state_q != ST_REQ)) begin
      state_d = ST_REQ;
      req_d   = 1'b1;
      we_d    = start_we_i;
      addr_d  = start_addr_i;
      wdata_d = start_wdata_i;
      cnt_d   = '0;
    end
  end

  assign busy_c_o    = (state_q == ST_REQ);
  assign done_c_o    = (state_q == ST_DONE);
  assign wb_ok_c_o   = !kill_q && !tout_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q, 2'b00};
  assign mem_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM latch, word lw/sw over a req/ack port and
// writeback muxing toward WB.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ALUop_i,
  input  logic        WriteReg_i,
  input  logic [4:0]  WriteDataNum_i,
  input  logic [31:0] WriteData_i,
  input  logic [31:0] MemAddr_i,
  input  logic [31:0] StoreData_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        WriteReg_o,
  output logic [4:0]  WriteDataNum_o,
  output logic [31:0] WriteData_o,
  output logic        StallReq,
  output logic        misalign_o,
  output logic        bus_err_o
);

  ex_mem_t     lat_q, lat_d;
  logic        load_c, start_c;
  logic        busy_c, done_c, wb_ok_c;
  logic [31:0] rdata_c;
  logic        lat_mem_c, lat_mis_c;

  assign StallReq = busy_c;
  assign load_c   = !stall_i && !busy_c;
  assign start_c  = load_c && !flush_i && is_mem_op(ALUop_i) && (MemAddr_i[1:0] == 2'b00);

  always_comb begin
    lat_d = lat_q;
    if (load_c) begin
      if (flush_i) begin
        lat_d = '0;
      end else begin
        lat_d.op      = ALUop_i;
        lat_d.wr      = WriteReg_i;
        lat_d.rd      = WriteDataNum_i;
        lat_d.data    = WriteData_i;
        lat_d.addr_lo = MemAddr_i[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lat_q <= '0;
    else     lat_q <= lat_d;
  end

  mem_bus_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_bus (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_c),
    .start_we_i   (ALUop_i == OP_SW),
    .start_addr_i (MemAddr_i[31:2]),
    .start_wdata_i(StoreData_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_c_o     (busy_c),
    .done_c_o     (done_c),
    .wb_ok_c_o    (wb_ok_c),
    .rdata_o      (rdata_c),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .bus_err_o    (bus_err_o)
  );

  assign lat_mem_c = is_mem_op(lat_q.op);
  assign lat_mis_c = lat_mem_c && (lat_q.addr_lo != 2'b00);
  assign misalign_o     = lat_mis_c;
  assign WriteDataNum_o = lat_q.rd;

  // Loads write back only from DONE and only if neither killed nor timed out.
  always_comb begin
    WriteReg_o  = lat_q.wr;
    WriteData_o = lat_q.data;
    if ((lat_q.op == OP_LW) && !lat_mis_c) begin
      WriteReg_o  = lat_q.wr && done_c && wb_ok_c;
      WriteData_o = rdata_c;
    end else if (lat_mem_c) begin
      WriteReg_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instruction stream, memory responder
// with programmable wait states, and a program-order reference memory.
module tb_mem_stage;

  localparam int unsigned TO = 16;
  localparam logic [4:0] T_LW = 5'b10100;
  localparam logic [4:0] T_SW = 5'b10101;
  localparam logic [4:0] T_ADD = 5'b01101;

  logic        clk, rst;
  logic [4:0]  ALUop_i;
  logic        WriteReg_i;
  logic [4:0]  WriteDataNum_i;
  logic [31:0] WriteData_i, MemAddr_i, StoreData_i;
  logic        stall_i, flush_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        WriteReg_o;
  logic [4:0]  WriteDataNum_o;
  logic [31:0] WriteData_o;
  logic        StallReq, misalign_o, bus_err_o;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ALUop_i(ALUop_i), .WriteReg_i(WriteReg_i),
    .WriteDataNum_i(WriteDataNum_i), .WriteData_i(WriteData_i),
    .MemAddr_i(MemAddr_i), .StoreData_i(StoreData_i), .stall_i(stall_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .WriteReg_o(WriteReg_o),
    .WriteDataNum_o(WriteDataNum_o), .WriteData_o(WriteData_o),
    .StallReq(StallReq), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  num;
    logic [31:0] data;
    logic        mis;
    logic        chk;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          waits;   // -1: never acknowledge
  } req_exp_t;

  wb_exp_t     wb_q[$];
  req_exp_t    rq_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem[1024];
  logic [31:0] phys_mem[1024];
  logic        pend_kill;
  logic [4:0]  nonmem[11];

  function automatic logic [31:0] seed_word(input int i);
    if (i == 64) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one instruction: predict its outcome, then hold it until a load edge.
  task automatic issue(input logic [4:0] op, input logic wr, input logic [4:0] rd,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic flush_ld,
                       input logic kill, input int waits);
    wb_exp_t e;
    logic is_mem, aligned, enters;
    int idx, cyc;
    is_mem  = (op == T_LW) || (op == T_SW);
    aligned = (addr[1:0] == 2'b00);
    enters  = is_mem && aligned && !flush_ld;
    idx     = int'(addr[11:2]);
    e = '{1'b0, rd, wdata, 1'b0, 1'b0};
    if (flush_ld) begin
      e.num = 5'd0;
    end else if (!is_mem) begin
      e.wr = wr; e.chk = 1'b1;
    end else if (!aligned) begin
      e.mis = 1'b1;
    end else if (op == T_LW) begin
      if (wr && !kill && waits >= 0) begin
        e.wr = 1'b1; e.data = ref_mem[idx]; e.chk = 1'b1;
      end
    end else if (waits >= 0) begin
      ref_mem[idx] = sdata;
    end
    wb_q.push_back(e);
    if (enters) rq_q.push_back('{{addr[31:2], 2'b00}, op == T_SW, sdata, waits});
    cyc = 0;
    forever begin
      if (StallReq) begin
        flush_i = pend_kill; pend_kill = 1'b0;
      end else begin
        flush_i = flush_ld;
      end
      ALUop_i = op; WriteReg_i = wr; WriteDataNum_i = rd; WriteData_i = wdata;
      MemAddr_i = addr; StoreData_i = sdata;
      stall_i = ($urandom_range(0, 3) == 0);
      if (!StallReq && !stall_i) break;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        $display("FAIL issue_wait: got no load edge after %0d cycles expected <= 200", cyc);
        $fatal(1, "stage stuck");
      end
    end
    @(posedge clk); #1;
    pend_kill = enters && kill;
  endtask

  // Writeback monitor: an instruction retires at each load edge.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (StallReq) check("wb_en_during_req", 32'(WriteReg_o), 32'd0);
      if (!StallReq && !stall_i) begin
        if (wb_q.size() == 0) begin
          check("wb_queue_nonempty", 32'd0, 32'd1);
        end else begin
          e = wb_q.pop_front();
          check("wb_en", 32'(WriteReg_o), 32'(e.wr));
          check("misalign", 32'(misalign_o), 32'(e.mis));
          if (e.chk) begin
            check("wb_num", 32'(WriteDataNum_o), 32'(e.num));
            check("wb_data", WriteData_o, e.data);
          end
        end
      end
    end
  end

  // Memory responder and request checker.
  initial begin
    req_exp_t cur;
    bit active;
    int cnt;
    logic ack;
    active = 1'b0; cnt = 0; cur = '{32'd0, 1'b0, 32'd0, 0};
    mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0; mem_ack_i = 1'b0;
        continue;
      end
      if (mem_req_o) begin
        if (!active) begin
          if (rq_q.size() == 0) begin
            check("req_expected", 32'd0, 32'd1);
            cur = '{mem_addr_o, mem_we_o, mem_wdata_o, 0};
          end else begin
            cur = rq_q.pop_front();
          end
          active = 1'b1; cnt = 0;
        end
        check("req_addr", mem_addr_o, cur.addr);
        check("req_we", 32'(mem_we_o), 32'(cur.we));
        if (cur.we) check("req_wdata", mem_wdata_o, cur.wdata);
        cnt++;
        ack = (cur.waits >= 0) && (cnt == cur.waits + 1);
        mem_ack_i = ack;
        mem_rdata_i = phys_mem[mem_addr_o[11:2]];
        if (ack && mem_we_o) phys_mem[mem_addr_o[11:2]] = mem_wdata_o;
      end else begin
        mem_ack_i = 1'b0;
        mem_rdata_i = $urandom;
        if (active) begin
          check("req_len", 32'(cnt), (cur.waits < 0) ? 32'(TO) : 32'(cur.waits + 1));
          check("bus_err_pulse", 32'(bus_err_o), (cur.waits < 0) ? 32'd1 : 32'd0);
          active = 1'b0;
        end else begin
          check("bus_err_idle", 32'(bus_err_o), 32'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    logic [31:0] addr;
    int r, waits;
    nonmem = '{5'b10000, 5'b10001, 5'b10010, 5'b01100, 5'b01101, 5'b01110,
               5'b01000, 5'b00110, 5'b01001, 5'b00101, 5'b00100};
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = seed_word(i);
      phys_mem[i] = seed_word(i);
    end
    rst = 1'b1; stall_i = 1'b1; flush_i = 1'b0; pend_kill = 1'b0;
    ALUop_i = 5'd0; WriteReg_i = 1'b0; WriteDataNum_i = 5'd0; WriteData_i = 32'd0;
    MemAddr_i = 32'd0; StoreData_i = 32'd0;
    wb_q.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_stall", 32'(StallReq), 32'd0);
    check("rst_wb_data", WriteData_o, 32'd0);
    rst = 1'b0;

    issue(T_ADD, 1'b1, 5'd5, 32'h7, 32'h3, 32'd0, 1'b0, 1'b0, 0);
    issue(T_LW, 1'b1, 5'd3, 32'd0, 32'h100, 32'd0, 1'b0, 1'b0, 0);
    issue(T_SW, 1'b0, 5'd0, 32'd0, 32'h200, 32'h1234, 1'b0, 1'b0, 3);
    issue(T_LW, 1'b1, 5'd7, 32'd0, 32'h104, 32'd0, 1'b0, 1'b0, -1);
    issue(T_LW, 1'b1, 5'd8, 32'd0, 32'h102, 32'd0, 1'b0, 1'b0, 0);
    issue(T_LW, 1'b1, 5'd9, 32'd0, 32'h108, 32'd0, 1'b0, 1'b1, 2);
    issue(T_LW, 1'b1, 5'd10, 32'd0, 32'h200, 32'd0, 1'b0, 1'b0, 1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      op = (r < 35) ? T_LW : (r < 60) ? T_SW : nonmem[$urandom_range(0, 10)];
      addr = 32'h100 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      waits = ($urandom_range(0, 29) == 0) ? -1 : int'($urandom_range(0, 4));
      issue(op, 1'($urandom), 5'($urandom), $urandom, addr, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, waits);
    end
    issue(T_ADD, 1'b1, 5'd1, 32'h55, 32'h0, 32'd0, 1'b0, 1'b0, 0);

    // Reset in the middle of an outstanding load.
    issue(T_LW, 1'b1, 5'd4, 32'd0, 32'h104, 32'd0, 1'b0, 1'b0, -1);
    stall_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("pre_rst_req", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_req", 32'(mem_req_o), 32'd0);
    check("arst_we", 32'(mem_we_o), 32'd0);
    check("arst_addr", mem_addr_o, 32'd0);
    check("arst_wdata", mem_wdata_o, 32'd0);
    check("arst_stall", 32'(StallReq), 32'd0);
    check("arst_wb_en", 32'(WriteReg_o), 32'd0);
    check("arst_wb_num", 32'(WriteDataNum_o), 32'd0);
    check("arst_wb_data", WriteData_o, 32'd0);
    check("arst_misalign", 32'(misalign_o), 32'd0);
    check("arst_bus_err", 32'(bus_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_req", 32'(mem_req_o), 32'd0);
    check("post_rst_stall", 32'(StallReq), 32'd0);
    check("req_queue_drained", 32'(rq_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
